// File: rtl/sipo_frame_receiver.sv
// Serial-in/parallel-out frame receiver: gathers WIDTH serial bits (LSB- or MSB-first)
// and offers the finished word on a one-entry valid/ready output buffer.
module sipo_frame_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sd,
  input  logic             i_sv,
  input  logic             i_start,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_p,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_abort
);

  localparam int CW = $clog2(WIDTH + 1);

  // Output handshake: a word moves to the consumer on a rising edge where
  // o_valid & i_ready are both 1; o_p is held stable while o_valid & ~i_ready,
  // and i_ready has no effect while o_valid is 0.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] p_d;
  logic             valid_d;
  logic             overrun_d;
  logic             abort_d;
  logic             complete;

  // dir=0 enters at the MSB and moves right; dir=1 enters at bit0 and moves left.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                 input logic             bit_in,
                                                 input logic             dir);
    return dir ? {base[WIDTH-2:0], bit_in} : {bit_in, base[WIDTH-1:1]};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      o_p       <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      o_p       <= p_d;
      o_valid   <= valid_d;
      o_overrun <= overrun_d;
      o_abort   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    p_d       = o_p;
    valid_d   = o_valid & ~i_ready;
    overrun_d = 1'b0;
    abort_d   = 1'b0;
    complete  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_sv && i_start) begin
          dir_d   = i_dir;
          sr_d    = shift_in('0, i_sd, i_dir);
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (i_sv) begin
          if (i_start) begin
            // A new start always wins, even on what would have been the last bit.
            abort_d = 1'b1;
            dir_d   = i_dir;
            sr_d    = shift_in('0, i_sd, i_dir);
            cnt_d   = CW'(1);
          end else begin
            sr_d = shift_in(sr_q, i_sd, dir_q);
            if (cnt_q == CW'(WIDTH - 1)) begin
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A finished word either refills the buffer (empty, or draining this edge) or is dropped.
    if (complete) begin
      if (o_valid && !i_ready) begin
        overrun_d = 1'b1;
      end else begin
        p_d     = sr_d;
        valid_d = 1'b1;
      end
    end
  end

  assign o_busy = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver (WIDTH=4): per-cycle vector table plus
// hand-written async reset sequence and a scoreboard of words accepted by the consumer.
module tb_sipo_frame_receiver;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         sd, sv, start, dir, ready;
  logic [W-1:0] p;
  logic         valid, busy, overrun, abort_p;

  int n_checks;
  int n_fail;

  typedef struct {
    logic         sv, sd, st, dir, rdy;
    logic [W-1:0] p;
    logic         v, b, ov, ab;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           reset_at;

  sipo_frame_receiver #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_sd      (sd),
    .i_sv      (sv),
    .i_start   (start),
    .i_dir     (dir),
    .o_p       (p),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_busy    (busy),
    .o_overrun (overrun),
    .o_abort   (abort_p)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [W-1:0] ep, input logic ev,
                               input logic eb, input logic eov, input logic eab);
    chk("o_p", idx, 32'(p), 32'(ep));
    chk("o_valid", idx, 32'(valid), 32'(ev));
    chk("o_busy", idx, 32'(busy), 32'(eb));
    chk("o_overrun", idx, 32'(overrun), 32'(eov));
    chk("o_abort", idx, 32'(abort_p), 32'(eab));
  endtask

  function automatic void add(input logic sv_i, input logic sd_i, input logic st_i,
                              input logic dir_i, input logic rdy_i, input logic [W-1:0] p_i,
                              input logic v_i, input logic b_i, input logic ov_i, input logic ab_i);
    vec_t t;
    t.sv = sv_i; t.sd = sd_i; t.st = st_i; t.dir = dir_i; t.rdy = rdy_i;
    t.p = p_i; t.v = v_i; t.b = b_i; t.ov = ov_i; t.ab = ab_i;
    vecs.push_back(t);
  endfunction

  // Driver: inputs change on the falling edge, outputs are checked on the next falling edge.
  task automatic apply(input vec_t t, input int idx);
    logic [W-1:0] exp_word;
    sv = t.sv; sd = t.sd; start = t.st; dir = t.dir; ready = t.rdy;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_transfer", idx, 32'(p), 32'hFFFF_FFFF);
      end else begin
        exp_word = exp_q.pop_front();
        chk("sb_transfer", idx, 32'(p), 32'(exp_word));
      end
    end
    @(negedge clk);
    check_outputs(idx, t.p, t.v, t.b, t.ov, t.ab);
  endtask

  task automatic do_async_reset(input int idx);
    #2 rst_n = 1'b0;
    #1 check_outputs(idx, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    sv = 1'b0; sd = 1'b0; start = 1'b0; dir = 1'b0; ready = 1'b0;
    @(negedge clk);
    check_outputs(idx, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; sv = 1'b0; sd = 1'b0; start = 1'b0; dir = 1'b0; ready = 1'b0;

    // LSB-first 1,0,1,1 -> 0xD; hold while not ready, then drain.
    add(1,1,1,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'hD,1,0,0,0);
    add(0,0,0,0,0, 4'hD,1,0,0,0);
    add(0,0,0,0,1, 4'hD,0,0,0,0);
    // MSB-first 1,0,gap,gap,1,1 -> 0xB; dir toggles and a bare start mid-frame are ignored.
    add(1,1,1,1,0, 4'hD,0,1,0,0);
    add(1,0,0,0,0, 4'hD,0,1,0,0);
    add(0,0,0,0,0, 4'hD,0,1,0,0);
    add(0,0,1,0,0, 4'hD,0,1,0,0);
    add(1,1,0,0,0, 4'hD,0,1,0,0);
    add(1,1,0,0,0, 4'hB,1,0,0,0);
    add(0,0,0,0,1, 4'hB,0,0,0,0);
    add(1,1,0,0,0, 4'hB,0,0,0,0);
    add(0,0,1,0,0, 4'hB,0,0,0,0);
    // Not ready: 0xA then 0x5 back-to-back -> 0x5 dropped with overrun pulse.
    add(1,0,1,0,0, 4'hB,0,1,0,0);
    add(1,1,0,0,0, 4'hB,0,1,0,0);
    add(1,0,0,0,0, 4'hB,0,1,0,0);
    add(1,1,0,0,0, 4'hA,1,0,0,0);
    add(1,1,1,0,0, 4'hA,1,1,0,0);
    add(1,0,0,0,0, 4'hA,1,1,0,0);
    add(1,1,0,0,0, 4'hA,1,1,0,0);
    add(1,0,0,0,0, 4'hA,1,0,1,0);
    add(0,0,0,0,0, 4'hA,1,0,0,0);
    add(0,0,0,0,1, 4'hA,0,0,0,0);
    // Ready held high: 0x3 then 0xC, each accepted, no overrun.
    add(1,1,1,0,1, 4'hA,0,1,0,0);
    add(1,1,0,0,1, 4'hA,0,1,0,0);
    add(1,0,0,0,1, 4'hA,0,1,0,0);
    add(1,0,0,0,1, 4'h3,1,0,0,0);
    add(1,0,1,0,1, 4'h3,0,1,0,0);
    add(1,0,0,0,1, 4'h3,0,1,0,0);
    add(1,1,0,0,1, 4'h3,0,1,0,0);
    add(1,1,0,0,1, 4'hC,1,0,0,0);
    add(0,0,0,0,1, 4'hC,0,0,0,0);
    // MSB-first 0x6 held, then 0x9 completes on the same edge 0x6 drains: valid stays high.
    add(1,0,1,1,0, 4'hC,0,1,0,0);
    add(1,1,0,1,0, 4'hC,0,1,0,0);
    add(1,1,0,1,0, 4'hC,0,1,0,0);
    add(1,0,0,1,0, 4'h6,1,0,0,0);
    add(1,1,1,1,0, 4'h6,1,1,0,0);
    add(1,0,0,1,0, 4'h6,1,1,0,0);
    add(1,0,0,1,0, 4'h6,1,1,0,0);
    add(1,1,0,1,1, 4'h9,1,0,0,0);
    add(0,0,0,0,1, 4'h9,0,0,0,0);
    // Two MSB-first bits, then restart LSB-first 0x6 -> abort pulse, direction re-latched.
    add(1,1,1,1,0, 4'h9,0,1,0,0);
    add(1,1,0,1,0, 4'h9,0,1,0,0);
    add(1,0,1,0,0, 4'h9,0,1,0,1);
    add(1,1,0,0,0, 4'h9,0,1,0,0);
    add(1,1,0,0,0, 4'h9,0,1,0,0);
    add(1,0,0,0,0, 4'h6,1,0,0,0);
    add(0,0,0,0,1, 4'h6,0,0,0,0);
    // Start on what would be the completing bit -> abort, new frame 0xA.
    add(1,1,1,0,0, 4'h6,0,1,0,0);
    add(1,0,0,0,0, 4'h6,0,1,0,0);
    add(1,1,0,0,0, 4'h6,0,1,0,0);
    add(1,0,1,0,0, 4'h6,0,1,0,1);
    add(1,1,0,0,0, 4'h6,0,1,0,0);
    add(1,0,0,0,0, 4'h6,0,1,0,0);
    add(1,1,0,0,0, 4'hA,1,0,0,0);
    add(0,0,0,0,1, 4'hA,0,0,0,0);
    // 0x5 left in the buffer and 3 bits of the next frame, then async reset.
    add(1,1,1,0,0, 4'hA,0,1,0,0);
    add(1,0,0,0,0, 4'hA,0,1,0,0);
    add(1,1,0,0,0, 4'hA,0,1,0,0);
    add(1,0,0,0,0, 4'h5,1,0,0,0);
    add(1,1,1,0,0, 4'h5,1,1,0,0);
    add(1,1,0,0,0, 4'h5,1,1,0,0);
    add(1,1,0,0,0, 4'h5,1,1,0,0);
    reset_at = vecs.size();
    // After reset: clean frame 0x9 LSB-first.
    add(1,1,1,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'h9,1,0,0,0);
    add(0,0,0,0,1, 4'h9,0,0,0,0);

    exp_q = '{4'hD, 4'hB, 4'hA, 4'h3, 4'hC, 4'h6, 4'h9, 4'h6, 4'hA, 4'h9};

    @(negedge clk);
    check_outputs(-1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == reset_at) do_async_reset(i);
      apply(vecs[i], i);
    end

    chk("sb_words_left", vecs.size(), 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
